// File: rtl/rob_nway.sv
// rob_nway: parametrised reorder buffer. N-wide dispatch, M-wide in-order
// retire, P writeback ports. On a branch flush it squashes younger entries
// (ROLLBACK) and then replays surviving rd mappings to rebuild the RAT (WALK).
module rob_nway #(
  parameter  int ROB_DEPTH = 16,
  parameter  int DISP_W    = 2,
  parameter  int RET_W     = 2,
  parameter  int WB_PORTS  = 4,
  parameter  int PRF_W     = 6,
  parameter  int ARF_W     = 5,
  localparam int AW        = $clog2(ROB_DEPTH),
  localparam int IW        = AW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DISP_W-1:0]         disp_valid,
  output logic                      disp_ready,
  input  logic [DISP_W-1:0]         disp_is_wb,
  input  logic [DISP_W*ARF_W-1:0]   disp_arf_id,
  input  logic [DISP_W*PRF_W-1:0]   disp_T,
  input  logic [DISP_W*PRF_W-1:0]   disp_T_old,
  output logic [DISP_W*IW-1:0]      disp_robid,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*IW-1:0]    wb_robid,
  output logic [RET_W-1:0]          ret_valid,
  output logic [RET_W-1:0]          ret_is_wb,
  output logic [RET_W*ARF_W-1:0]    ret_arf_id,
  output logic [RET_W*PRF_W-1:0]    ret_T,
  output logic [RET_W*PRF_W-1:0]    ret_T_old,
  output logic [RET_W*IW-1:0]       ret_robid,
  input  logic                      flush_valid,
  input  logic [IW-1:0]             flush_robid,
  output logic [1:0]                rob_state,
  output logic [RET_W-1:0]          walk_valid,
  output logic [RET_W*ARF_W-1:0]    walk_arf_id,
  output logic [RET_W*PRF_W-1:0]    walk_T,
  output logic [IW-1:0]             free_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RB = 2'b01, S_WALK = 2'b10} state_t;

  state_t state, state_n;
  logic [IW-1:0] alloc_ptr, retire_ptr, walk_ptr, fl_id;
  logic [ROB_DEPTH-1:0] valid_q, cmpl_q, iswb_q, rb_clr;
  logic [ARF_W-1:0] arf_q  [ROB_DEPTH];
  logic [PRF_W-1:0] t_q    [ROB_DEPTH];
  logic [PRF_W-1:0] told_q [ROB_DEPTH];

  logic [IW-1:0] disp_id [DISP_W];
  logic [IW-1:0] ret_id  [RET_W];
  logic [IW-1:0] walk_id [RET_W];
  logic [RET_W-1:0] ret_ok;
  logic [IW-1:0] disp_cnt, ret_cnt, occ, rb_span;
  logic flush_acc, run;
  logic unused_bits;

  // a is older than b when (a-b) wraps negative in the AW+1 id space
  function automatic logic older(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW-1:0] d;
    d = a - b;
    return d[IW-1];
  endfunction

  assign occ        = alloc_ptr - retire_ptr;
  assign free_cnt   = IW'(ROB_DEPTH) - occ;
  assign disp_ready = (state == S_IDLE) & ~flush_valid & (free_cnt >= IW'(DISP_W));
  assign rob_state  = state;
  // IDLE always takes a flush; elsewhere only a strictly older one restarts recovery
  assign flush_acc  = flush_valid & ((state == S_IDLE) | older(flush_robid, fl_id));
  assign rb_span    = alloc_ptr - fl_id;

  for (genvar i = 0; i < DISP_W; i++) begin : g_disp
    assign disp_id[i] = alloc_ptr + IW'(i);
    assign disp_robid[i*IW +: IW] = disp_id[i];
  end

  for (genvar k = 0; k < RET_W; k++) begin : g_lane
    assign ret_id[k]  = retire_ptr + IW'(k);
    assign walk_id[k] = walk_ptr + IW'(k);
    assign ret_ok[k]  = valid_q[ret_id[k][AW-1:0]] & cmpl_q[ret_id[k][AW-1:0]];
    assign ret_is_wb[k]               = iswb_q[ret_id[k][AW-1:0]];
    assign ret_arf_id[k*ARF_W +: ARF_W] = arf_q[ret_id[k][AW-1:0]];
    assign ret_T[k*PRF_W +: PRF_W]      = t_q[ret_id[k][AW-1:0]];
    assign ret_T_old[k*PRF_W +: PRF_W]  = told_q[ret_id[k][AW-1:0]];
    assign ret_robid[k*IW +: IW]        = ret_id[k];
    assign walk_valid[k] = (state == S_WALK) & valid_q[walk_id[k][AW-1:0]] &
                           iswb_q[walk_id[k][AW-1:0]] & older(walk_id[k], alloc_ptr);
    assign walk_arf_id[k*ARF_W +: ARF_W] = arf_q[walk_id[k][AW-1:0]];
    assign walk_T[k*PRF_W +: PRF_W]      = t_q[walk_id[k][AW-1:0]];
  end

  // Rollback mask: offset from fl_id in 1..span-1 means younger than fl_id, older than alloc_ptr
  for (genvar e = 0; e < ROB_DEPTH; e++) begin : g_rb
    logic [AW-1:0] d;
    assign d         = AW'(e) - fl_id[AW-1:0];
    assign rb_clr[e] = (d != '0) && ({1'b0, d} < rb_span);
  end

  // Dispatch lane count (lanes are contiguous from lane 0)
  always_comb begin
    disp_cnt = '0;
    for (int i = 0; i < DISP_W; i++)
      if (disp_ready && disp_valid[i]) disp_cnt = disp_cnt + 1'b1;
  end

  // Retire prefix: stop at the first entry that is not valid&complete
  always_comb begin
    run       = (state == S_IDLE) & ~flush_valid;
    ret_valid = '0;
    ret_cnt   = '0;
    for (int k = 0; k < RET_W; k++) begin
      run          = run & ret_ok[k];
      ret_valid[k] = run;
      ret_cnt      = ret_cnt + IW'(run);
    end
  end

  // Recovery FSM next state; a new accepted flush takes priority over walk exit
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (flush_valid) state_n = S_RB;
      S_RB:    state_n = flush_acc ? S_RB : S_WALK;
      S_WALK: begin
        if (flush_acc) state_n = S_RB;
        else if (!older(walk_ptr + IW'(RET_W), alloc_ptr)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Control state: pointers, valid/complete bits. Later writes win: WB, dispatch, retire, rollback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      alloc_ptr  <= '0;
      retire_ptr <= '0;
      walk_ptr   <= '0;
      fl_id      <= '0;
      valid_q    <= '0;
      cmpl_q     <= '0;
    end else begin
      state <= state_n;
      if (flush_acc) fl_id <= flush_robid;
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p] && valid_q[wb_robid[p*IW +: AW]]) cmpl_q[wb_robid[p*IW +: AW]] <= 1'b1;
      for (int i = 0; i < DISP_W; i++)
        if (disp_ready && disp_valid[i]) begin
          valid_q[disp_id[i][AW-1:0]] <= 1'b1;
          cmpl_q[disp_id[i][AW-1:0]]  <= 1'b0;
        end
      alloc_ptr <= alloc_ptr + disp_cnt;
      for (int k = 0; k < RET_W; k++)
        if (ret_valid[k]) begin
          valid_q[ret_id[k][AW-1:0]] <= 1'b0;
          cmpl_q[ret_id[k][AW-1:0]]  <= 1'b0;
        end
      retire_ptr <= retire_ptr + ret_cnt;
      if (state == S_WALK) walk_ptr <= walk_ptr + IW'(RET_W);
      if (state == S_RB) begin
        for (int e = 0; e < ROB_DEPTH; e++)
          if (rb_clr[e]) begin
            valid_q[e] <= 1'b0;
            cmpl_q[e]  <= 1'b0;
          end
        alloc_ptr <= fl_id + 1'b1;
        walk_ptr  <= retire_ptr;
      end
    end
  end

  // Entry payload: written on dispatch only, no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISP_W; i++)
      if (disp_ready && disp_valid[i]) begin
        iswb_q[disp_id[i][AW-1:0]] <= disp_is_wb[i];
        arf_q[disp_id[i][AW-1:0]]  <= disp_arf_id[i*ARF_W +: ARF_W];
        t_q[disp_id[i][AW-1:0]]    <= disp_T[i*PRF_W +: PRF_W];
        told_q[disp_id[i][AW-1:0]] <= disp_T_old[i*PRF_W +: PRF_W];
      end
  end

  // wrap bits of writeback ids do not select an entry
  always_comb begin
    unused_bits = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) unused_bits = unused_bits ^ wb_robid[p*IW + AW];
  end

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway with default parameters (depth 16, 2/2/4 lanes).
module tb_rob_nway;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  disp_valid, disp_is_wb;
  logic        disp_ready;
  logic [9:0]  disp_arf_id;
  logic [11:0] disp_T, disp_T_old;
  logic [9:0]  disp_robid;
  logic [3:0]  wb_valid;
  logic [19:0] wb_robid;
  logic [1:0]  ret_valid, ret_is_wb;
  logic [9:0]  ret_arf_id, ret_robid;
  logic [11:0] ret_T, ret_T_old;
  logic        flush_valid;
  logic [4:0]  flush_robid;
  logic [1:0]  rob_state, walk_valid;
  logic [9:0]  walk_arf_id;
  logic [11:0] walk_T;
  logic [4:0]  free_cnt;

  int checks = 0;
  int failures = 0;

  rob_nway dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_wb(disp_is_wb),
    .disp_arf_id(disp_arf_id), .disp_T(disp_T), .disp_T_old(disp_T_old),
    .disp_robid(disp_robid), .wb_valid(wb_valid), .wb_robid(wb_robid),
    .ret_valid(ret_valid), .ret_is_wb(ret_is_wb), .ret_arf_id(ret_arf_id),
    .ret_T(ret_T), .ret_T_old(ret_T_old), .ret_robid(ret_robid),
    .flush_valid(flush_valid), .flush_robid(flush_robid), .rob_state(rob_state),
    .walk_valid(walk_valid), .walk_arf_id(walk_arf_id), .walk_T(walk_T),
    .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    disp_valid = '0; disp_is_wb = '0; disp_arf_id = '0; disp_T = '0; disp_T_old = '0;
    wb_valid = '0; wb_robid = '0; flush_valid = 1'b0; flush_robid = '0;
  endtask

  task automatic do_reset;
    idle_in(); reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  // lane i carries id first+i: arf=id+1, T=id, T_old=id+20
  task automatic disp2(input int first, input logic [1:0] v, input logic [1:0] wb);
    disp_valid = v; disp_is_wb = wb;
    for (int i = 0; i < 2; i++) begin
      disp_arf_id[i*5 +: 5] = 5'(first + i + 1);
      disp_T[i*6 +: 6]      = 6'(first + i);
      disp_T_old[i*6 +: 6]  = 6'(first + i + 20);
    end
  endtask

  task automatic test_reset;
    do_reset(); #1;
    checks++; if (free_cnt !== 5'd16) begin failures++; $display("FAIL reset_free got=%0d exp=16", free_cnt); end
    checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", disp_ready); end
    checks++; if (ret_valid !== 2'b00) begin failures++; $display("FAIL reset_ret got=%b exp=00", ret_valid); end
    checks++; if (walk_valid !== 2'b00) begin failures++; $display("FAIL reset_walk got=%b exp=00", walk_valid); end
    checks++; if (rob_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", rob_state); end
  endtask

  task automatic test_fill;
    for (int c = 0; c < 8; c++) begin
      disp2(2*c, 2'b11, 2'b11); #1;
      checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL fill_ready c=%0d got=%b exp=1", c, disp_ready); end
      checks++; if (disp_robid !== {5'(2*c+1), 5'(2*c)}) begin failures++; $display("FAIL fill_robid c=%0d got=%h exp=%h", c, disp_robid, {5'(2*c+1), 5'(2*c)}); end
      tick();
    end
    disp2(16, 2'b11, 2'b11); #1;
    checks++; if (free_cnt !== 5'd0) begin failures++; $display("FAIL full_free got=%0d exp=0", free_cnt); end
    checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", disp_ready); end
    tick(); idle_in(); #1;
    checks++; if (free_cnt !== 5'd0) begin failures++; $display("FAIL full_drop got=%0d exp=0", free_cnt); end
  endtask

  task automatic test_retire_order;
    wb_valid = 4'b0001; wb_robid[4:0] = 5'd1; #1;
    checks++; if (ret_valid !== 2'b00) begin failures++; $display("FAIL wb1_same got=%b exp=00", ret_valid); end
    tick(); idle_in(); #1;
    checks++; if (ret_valid !== 2'b00) begin failures++; $display("FAIL wb1_next got=%b exp=00", ret_valid); end
    wb_valid = 4'b0001; wb_robid[4:0] = 5'd0; #1;
    checks++; if (ret_valid !== 2'b00) begin failures++; $display("FAIL wb0_same got=%b exp=00", ret_valid); end
    tick(); idle_in(); #1;
    checks++; if (ret_valid !== 2'b11) begin failures++; $display("FAIL ret_valid got=%b exp=11", ret_valid); end
    checks++; if (ret_robid !== {5'd1, 5'd0}) begin failures++; $display("FAIL ret_robid got=%h exp=%h", ret_robid, {5'd1, 5'd0}); end
    checks++; if (ret_T !== {6'd1, 6'd0}) begin failures++; $display("FAIL ret_T got=%h exp=%h", ret_T, {6'd1, 6'd0}); end
    checks++; if (ret_T_old !== {6'd21, 6'd20}) begin failures++; $display("FAIL ret_T_old got=%h exp=%h", ret_T_old, {6'd21, 6'd20}); end
    checks++; if (ret_arf_id !== {5'd2, 5'd1}) begin failures++; $display("FAIL ret_arf got=%h exp=%h", ret_arf_id, {5'd2, 5'd1}); end
    tick(); #1;
    checks++; if (free_cnt !== 5'd2) begin failures++; $display("FAIL ret_free got=%0d exp=2", free_cnt); end
    checks++; if (ret_valid !== 2'b00) begin failures++; $display("FAIL ret_after got=%b exp=00", ret_valid); end
  endtask

  // one dispatch per cycle, WB one cycle later, retire one cycle after that
  task automatic test_wrap;
    int exp_ret;
    exp_ret = 0;
    do_reset();
    for (int i = 0; i < 44; i++) begin
      idle_in();
      if (i < 40) disp2(i, 2'b01, 2'b01);
      if (i > 0 && i <= 40) begin wb_valid = 4'b0001; wb_robid[4:0] = 5'(i - 1); end
      #1;
      if (i < 40) begin
        checks++; if (disp_robid[4:0] !== 5'(i)) begin failures++; $display("FAIL wrap_robid i=%0d got=%0d exp=%0d", i, disp_robid[4:0], 5'(i)); end
      end
      if (ret_valid[0]) begin
        checks++; if (ret_robid[4:0] !== 5'(exp_ret) || ret_T[5:0] !== 6'(exp_ret)) begin
          failures++; $display("FAIL wrap_order got id=%0d T=%0d exp=%0d", ret_robid[4:0], ret_T[5:0], exp_ret);
        end
        exp_ret++;
      end
      tick();
    end
    idle_in(); #1;
    checks++; if (exp_ret !== 40) begin failures++; $display("FAIL wrap_count got=%0d exp=40", exp_ret); end
    checks++; if (free_cnt !== 5'd16) begin failures++; $display("FAIL wrap_free got=%0d exp=16", free_cnt); end
  endtask

  task automatic test_flush_walk;
    logic [9:0] wbt;
    wbt = 10'b1111101101;
    do_reset();
    for (int c = 0; c < 5; c++) begin disp2(2*c, 2'b11, {wbt[2*c+1], wbt[2*c]}); tick(); end
    idle_in(); flush_valid = 1'b1; flush_robid = 5'd4; #1;
    checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL fl_ready got=%b exp=0", disp_ready); end
    tick(); flush_valid = 1'b0; #1;
    checks++; if (rob_state !== 2'b01) begin failures++; $display("FAIL fl_rb got=%b exp=01", rob_state); end
    checks++; if (free_cnt !== 5'd6) begin failures++; $display("FAIL fl_rb_free got=%0d exp=6", free_cnt); end
    tick(); #1;
    checks++; if (rob_state !== 2'b10 || free_cnt !== 5'd11) begin failures++; $display("FAIL fl_walk1 got state=%b free=%0d exp=10/11", rob_state, free_cnt); end
    checks++; if (walk_valid !== 2'b01 || walk_arf_id[4:0] !== 5'd1 || walk_T[5:0] !== 6'd0) begin
      failures++; $display("FAIL fl_walk1_lane got v=%b arf=%0d T=%0d exp=01/1/0", walk_valid, walk_arf_id[4:0], walk_T[5:0]);
    end
    tick(); #1;
    checks++; if (walk_valid !== 2'b11 || walk_arf_id !== {5'd4, 5'd3} || walk_T !== {6'd3, 6'd2}) begin
      failures++; $display("FAIL fl_walk2 got v=%b arf=%h T=%h exp=11/%h/%h", walk_valid, walk_arf_id, walk_T, {5'd4, 5'd3}, {6'd3, 6'd2});
    end
    tick(); #1;
    checks++; if (rob_state !== 2'b10 || walk_valid !== 2'b00) begin failures++; $display("FAIL fl_walk3 got state=%b v=%b exp=10/00", rob_state, walk_valid); end
    tick(); #1;
    checks++; if (rob_state !== 2'b00 || disp_ready !== 1'b1 || free_cnt !== 5'd11) begin
      failures++; $display("FAIL fl_idle got state=%b rdy=%b free=%0d exp=00/1/11", rob_state, disp_ready, free_cnt);
    end
  endtask

  task automatic test_nested_flush;
    do_reset();
    for (int c = 0; c < 5; c++) begin disp2(2*c, 2'b11, 2'b11); tick(); end
    idle_in(); flush_valid = 1'b1; flush_robid = 5'd6; tick();
    flush_valid = 1'b0; tick(); #1;
    checks++; if (rob_state !== 2'b10 || free_cnt !== 5'd9) begin failures++; $display("FAIL nf_walk got state=%b free=%0d exp=10/9", rob_state, free_cnt); end
    flush_valid = 1'b1; flush_robid = 5'd3; tick(); flush_valid = 1'b0; #1;
    checks++; if (rob_state !== 2'b01) begin failures++; $display("FAIL nf_rb got=%b exp=01", rob_state); end
    tick(); #1;
    checks++; if (rob_state !== 2'b10 || free_cnt !== 5'd12) begin failures++; $display("FAIL nf_walk2 got state=%b free=%0d exp=10/12", rob_state, free_cnt); end
    flush_valid = 1'b1; flush_robid = 5'd8; tick(); flush_valid = 1'b0; #1;
    checks++; if (rob_state !== 2'b10 || free_cnt !== 5'd12) begin failures++; $display("FAIL nf_ignore got state=%b free=%0d exp=10/12", rob_state, free_cnt); end
    tick(); #1;
    checks++; if (rob_state !== 2'b00) begin failures++; $display("FAIL nf_idle got=%b exp=00", rob_state); end
    disp2(4, 2'b01, 2'b01); #1;
    checks++; if (disp_robid[4:0] !== 5'd4) begin failures++; $display("FAIL nf_alloc got=%0d exp=4", disp_robid[4:0]); end
    tick(); idle_in();
  endtask

  task automatic test_squash_wb;
    do_reset();
    for (int c = 0; c < 3; c++) begin disp2(2*c, 2'b11, 2'b11); tick(); end
    idle_in(); flush_valid = 1'b1; flush_robid = 5'd2; tick();
    flush_valid = 1'b0; wb_valid = 4'b0011; wb_robid[4:0] = 5'd4; wb_robid[9:5] = 5'd1; #1;
    checks++; if (rob_state !== 2'b01) begin failures++; $display("FAIL sq_rb got=%b exp=01", rob_state); end
    tick(); wb_valid = '0; tick(); tick(); #1;
    checks++; if (rob_state !== 2'b00 || free_cnt !== 5'd13 || ret_valid !== 2'b00) begin
      failures++; $display("FAIL sq_idle got state=%b free=%0d ret=%b exp=00/13/00", rob_state, free_cnt, ret_valid);
    end
    wb_valid = 4'b0111; wb_robid[4:0] = 5'd0; wb_robid[9:5] = 5'd2; wb_robid[14:10] = 5'd4;
    tick(); wb_valid = '0; #1;
    checks++; if (ret_valid !== 2'b11 || ret_robid !== {5'd1, 5'd0}) begin failures++; $display("FAIL sq_ret1 got v=%b id=%h exp=11/%h", ret_valid, ret_robid, {5'd1, 5'd0}); end
    tick(); #1;
    checks++; if (ret_valid !== 2'b01 || ret_robid[4:0] !== 5'd2) begin failures++; $display("FAIL sq_ret2 got v=%b id=%0d exp=01/2", ret_valid, ret_robid[4:0]); end
    tick(); #1;
    checks++; if (ret_valid !== 2'b00 || free_cnt !== 5'd16) begin failures++; $display("FAIL sq_empty got v=%b free=%0d exp=00/16", ret_valid, free_cnt); end
    disp2(3, 2'b11, 2'b11); #1;
    checks++; if (disp_robid !== {5'd4, 5'd3}) begin failures++; $display("FAIL sq_realloc got=%h exp=%h", disp_robid, {5'd4, 5'd3}); end
    tick(); idle_in(); tick(); #1;
    checks++; if (ret_valid !== 2'b00) begin failures++; $display("FAIL sq_noret got=%b exp=00", ret_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_retire_order();
    test_wrap();
    test_flush_walk();
    test_nested_flush();
    test_squash_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
